// File: rtl/button_ctrl_if.sv
// button_ctrl_if: board-pin and processor-side signals of the button block.
// The master side drives raw buttons and the read strobe.
interface button_ctrl_if;
  logic [3:0] btn_raw;
  logic       rd_en;
  logic [2:0] button_code;
  logic [3:0] btn_level;
  logic [3:0] press_pulse;

  modport master (
    output btn_raw,
    output rd_en,
    input  button_code,
    input  btn_level,
    input  press_pulse
  );

  modport slave (
    input  btn_raw,
    input  rd_en,
    output button_code,
    output btn_level,
    output press_pulse
  );
endinterface

// File: rtl/button_ctrl.sv
// button_ctrl: synchronized, debounced, priority-encoded push buttons.
// Define BUTTON_LATCH_EN for a sticky button_code cleared by rd_en.
module button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input logic          clock,
  input logic          reset,
  button_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ARM_ON,
    HELD,
    ARM_OFF
  } state_t;

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [3:0]       meta;
  logic [3:0]       s;
  state_t           state   [4];
  state_t           state_d [4];
  logic [CNT_W-1:0] cnt     [4];
  logic [CNT_W-1:0] cnt_d   [4];
  logic [3:0]       level;
  logic [3:0]       level_d;
  logic [3:0]       pulse;
  logic [3:0]       pulse_d;
  logic [2:0]       code;
  logic [2:0]       code_d;

  // U > R > D > L
  function automatic logic [2:0] encode(
    input logic [3:0] b
  );
    if (b[0]) return 3'd1;
    if (b[1]) return 3'd2;
    if (b[2]) return 3'd3;
    if (b[3]) return 3'd4;
    return 3'd0;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      meta  <= '0;
      s     <= '0;
      level <= '0;
      pulse <= '0;
      code  <= '0;
      for (int i = 0; i < 4; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      meta  <= bus.btn_raw;
      s     <= meta;
      level <= level_d;
      pulse <= pulse_d;
      code  <= code_d;
      for (int i = 0; i < 4; i++) begin
        state[i] <= state_d[i];
        cnt[i]   <= cnt_d[i];
      end
    end
  end

  // Counter is cleared on every bounce and every accepted edge.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      state_d[i] = state[i];
      cnt_d[i]   = '0;
      unique case (state[i])
        IDLE: begin
          if (s[i]) state_d[i] = ARM_ON;
        end
        ARM_ON: begin
          if (!s[i])
            state_d[i] = IDLE;
          else if (cnt[i] == LAST)
            state_d[i] = HELD;
          else
            cnt_d[i] = cnt[i] + CNT_W'(1);
        end
        HELD: begin
          if (!s[i]) state_d[i] = ARM_OFF;
        end
        ARM_OFF: begin
          if (s[i])
            state_d[i] = HELD;
          else if (cnt[i] == LAST)
            state_d[i] = IDLE;
          else
            cnt_d[i] = cnt[i] + CNT_W'(1);
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      level_d[i] = (state_d[i] == HELD) ||
                   (state_d[i] == ARM_OFF);
      pulse_d[i] = (state[i] == ARM_ON) &&
                   (state_d[i] == HELD);
    end
`ifdef BUTTON_LATCH_EN
    // A read that overlaps a visible pulse keeps the fresh code.
    code_d = code;
    if (|pulse_d)
      code_d = encode(pulse_d);
    else if (bus.rd_en && !(|pulse))
      code_d = '0;
`else
    code_d = encode(level_d);
`endif
  end

  assign bus.btn_level   = level;
  assign bus.press_pulse = pulse;
  assign bus.button_code = code;

endmodule

// File: tb/tb_button_ctrl.sv
// tb_button_ctrl: directed vectors plus a run-length debounce model.
// Honours BUTTON_LATCH_EN the same way the design does.
module tb_button_ctrl;

  localparam int DC = 4;

  logic clk;
  logic rst;

  button_ctrl_if bus ();

  button_ctrl #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (3)
  ) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  task automatic chk(
    input string name,
    input logic [3:0] act,
    input logic [3:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Lowest set bit wins: bit k maps to code k+1.
  function automatic logic [2:0] m_enc(
    input logic [3:0] b
  );
    logic [2:0] c;
    c = 3'd0;
    for (int k = 3; k >= 0; k--)
      if (b[k]) c = 3'(k + 1);
    return c;
  endfunction

  // Model: a level flips once the synchronized input has
  // disagreed with it on DC+1 consecutive edges (one to arm,
  // DC to count).
  logic [3:0] m_s1, m_s, m_level, m_pulse, nl, np;
  logic [2:0] m_code;
  int run [4];

  always @(posedge clk) begin
    if (rst) begin
      m_s1 = '0; m_s = '0;
      m_level = '0; m_pulse = '0; m_code = '0;
      for (int i = 0; i < 4; i++) run[i] = 0;
    end else begin
      nl = m_level;
      np = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_s[i] != m_level[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == DC + 1) begin
            nl[i] = m_s[i];
            np[i] = m_s[i];
            run[i] = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
`ifdef BUTTON_LATCH_EN
      if (np != 0)
        m_code = m_enc(np);
      else if (bus.rd_en && m_pulse == 0)
        m_code = '0;
`else
      m_code = m_enc(nl);
`endif
      m_level = nl;
      m_pulse = np;
      m_s = m_s1;
      m_s1 = bus.btn_raw;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_level", bus.btn_level, m_level);
      chk("m_pulse", bus.press_pulse, m_pulse);
      chk("m_code", {1'b0, bus.button_code},
          {1'b0, m_code});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.btn_raw = '0;
    bus.rd_en = 1'b0;
    tick(2);
    rst = 1'b0;
  endtask

  task automatic lit(
    input string name,
    input logic [3:0] lv,
    input logic [3:0] pp,
    input logic [2:0] cd
  );
    chk({name, "_level"}, bus.btn_level, lv);
    chk({name, "_pulse"}, bus.press_pulse, pp);
    chk({name, "_code"}, {1'b0, bus.button_code},
        {1'b0, cd});
  endtask

  initial begin
    do_reset();
    cmp_en = 1'b1;
    lit("rst", 4'h0, 4'h0, 3'd0);

    // Up: accepted after edge 2+DC.
    bus.btn_raw = 4'b0001;
    tick(6);
    lit("up_e5", 4'h0, 4'h0, 3'd0);
    tick(1);
    lit("up_e6", 4'h1, 4'h1, 3'd1);
    tick(1);
    lit("up_e7", 4'h1, 4'h0, 3'd1);
    bus.btn_raw = 4'b0000;
    tick(6);
    lit("upr_e5", 4'h1, 4'h0, 3'd1);
    tick(1);
`ifdef BUTTON_LATCH_EN
    lit("upr_e6", 4'h0, 4'h0, 3'd1);
`else
    lit("upr_e6", 4'h0, 4'h0, 3'd0);
`endif

    // Glitchy right button.
    do_reset();
    bus.btn_raw = 4'b0010; tick(3);
    bus.btn_raw = 4'b0000; tick(1);
    bus.btn_raw = 4'b0010; tick(3);
    bus.btn_raw = 4'b0000; tick(8);
    lit("glitch", 4'h0, 4'h0, 3'd0);

    // Left and right together.
    do_reset();
    bus.btn_raw = 4'b1010;
    tick(7);
    lit("lr", 4'ha, 4'ha, 3'd2);

    // Down held, read later, then released.
    do_reset();
    bus.btn_raw = 4'b0100;
    tick(7);
    lit("dn", 4'h4, 4'h4, 3'd3);
    tick(20);
    lit("dn_hold", 4'h4, 4'h0, 3'd3);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    bus.btn_raw = 4'b0000;
`ifdef BUTTON_LATCH_EN
    lit("dn_rd", 4'h4, 4'h0, 3'd0);
`else
    lit("dn_rd", 4'h4, 4'h0, 3'd3);
`endif
    tick(6);
`ifdef BUTTON_LATCH_EN
    lit("dnr_e5", 4'h4, 4'h0, 3'd0);
`else
    lit("dnr_e5", 4'h4, 4'h0, 3'd3);
`endif
    tick(1);
    lit("dnr_e6", 4'h0, 4'h0, 3'd0);

    // Read in the same cycle as the pulse.
    do_reset();
    bus.btn_raw = 4'b0001;
    tick(7);
    lit("rdp", 4'h1, 4'h1, 3'd1);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    lit("rdp_keep", 4'h1, 4'h0, 3'd1);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
`ifdef BUTTON_LATCH_EN
    lit("rdp_clr", 4'h1, 4'h0, 3'd0);
`else
    lit("rdp_clr", 4'h1, 4'h0, 3'd1);
`endif

    // Reset mid-count, then re-debounce the held button.
    do_reset();
    bus.btn_raw = 4'b1000;
    tick(5);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    lit("rst_mid", 4'h0, 4'h0, 3'd0);
    tick(6);
    lit("lf_e5", 4'h0, 4'h0, 3'd0);
    tick(1);
    lit("lf_e6", 4'h8, 4'h8, 3'd4);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    lit("rst_held", 4'h0, 4'h0, 3'd0);
    tick(7);
    lit("lf2_e6", 4'h8, 4'h8, 3'd4);
    tick(2);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_ctrl.md
# button_ctrl

Debounced, encoded front-panel button interface. It conditions the four raw push buttons (BTNU/BTNR/BTND/BTNL) into a 3-bit direction code for the processor's memory-mapped read at data address 0. It sits between the board pins and the read-data mux in the top-level wrapper, and runs on the 25 MHz system clock. Each button gets a two-flop synchronizer, a per-button debounce FSM, single-cycle press pulses and a priority encoder; an optional read-clear latch ensures no press is missed by slow game loops.

## Interface
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (10 ms at 25 MHz); legal range 1 to 2^CNT_W−1.
- CNT_W, 18, debounce counter width.
- clock  in  1  system clock (25 MHz).
- reset  in  1  reset, synchronous and active-high.
- btn_raw  in  4  asynchronous raw buttons {L,D,R,U} (bit0 = U).
- rd_en  in  1  processor read strobe: data-memory access to address 0 with write enable low, one cycle.
- button_code  out  3  0 = none, 1 = up, 2 = right, 3 = down, 4 = left; 5–7 never driven.
- btn_level  out  4  debounced levels, {L,D,R,U}.
- press_pulse  out  4  one-cycle pulse per accepted rising edge of btn_level.

## Operation
- Synchronizer: two flops per bit; the output is s[3:0].
- Per-button FSM states:
  - IDLE (level 0, cnt 0): s=1 → ARM_ON.
  - ARM_ON (level 0): while s=1, cnt++; when s=1 and cnt==DEBOUNCE_CYCLES−1 → HELD, level←1, pulse←1, cnt←0; if s=0 → IDLE, cnt←0.
  - HELD (level 1): s=0 → ARM_OFF.
  - ARM_OFF (level 1): while s=0, cnt++; when s=0 and cnt==DEBOUNCE_CYCLES−1 → IDLE, level←0, cnt←0 (no pulse on release); if s=1 → HELD, cnt←0.
- Counter never wraps: it is cleared on every bounce and on every accepted transition.
- Encoder priority when several are active in the same cycle: U > R > D > L.
- button_code source depends on BUTTON_LATCH_EN (see Configuration).

## Timing
- Reset values: all FSMs IDLE, counters 0, sync flops 0, btn_level 0, press_pulse 0, button_code 0.
- Reset asserted mid-count or while held: everything returns to reset values on the next edge. A button still held after reset deasserts must be re-debounced from IDLE and produces a fresh pulse.
- Press latency, raw stable high sampled at edge 0:
  - 2 edges of synchronization, then DEBOUNCE_CYCLES edges of counting.
  - btn_level and press_pulse go high together after edge 2+DEBOUNCE_CYCLES.
  - press_pulse drops on the following edge.
- Release latency is the same, 2+DEBOUNCE_CYCLES edges, with no pulse.
- A glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) produces no level change and no pulse.
- All outputs are registered. button_code is valid in the same cycle as the press_pulse that caused it.
- The processor samples button_code combinationally through the read mux in the cycle rd_en is high. Clearing takes effect on the following edge.

## Configuration
- BUTTON_LATCH_EN defined:
  - button_code is a sticky register.
  - Any press_pulse loads the priority-encoded code of the pulsing buttons.
  - rd_en clears it to 0 on the next edge.
  - If rd_en and a press_pulse occur in the same cycle, the new code is loaded, not cleared.
  - A second press before a read overwrites the first.
- BUTTON_LATCH_EN undefined:
  - button_code is the registered priority encode of btn_level.
  - It is nonzero for as long as the button is held.
  - rd_en is ignored.

## Test plan
Simulate with DEBOUNCE_CYCLES=4, CNT_W=3.
- Reset then hold btn_raw=4'b0001 → btn_level[0]=1 and press_pulse=4'b0001 for exactly one cycle, 6 edges after the first sampled high; button_code=1.
- Drive btn_raw[1] high for 3 cycles, low for 1, then high for 3 → no pulse, btn_level stays 0, button_code stays 0.
- Assert 4'b1010 (L and R) simultaneously, stable → both pulses in the same cycle; button_code=2 (R over L).
- Latch build: press D, wait 20 cycles, assert rd_en → code 3 while held; 0 after the rd_en edge; remains 0 through release. Non-latch build: same stimulus → 3 until 6 edges after release, rd_en has no effect.
- Latch build: assert rd_en in the same cycle as press_pulse[0] → button_code=1 after that edge, not 0.
- Assert reset while btn_raw[3] is held and the counter is at 2 → all outputs 0 next edge. With the button still held after reset deasserts: pulse after 6 more edges, button_code=4.
